fust_m_sched: RTL and testbench

- Issue scheduler for the matrix-multiply functional-unit status table in the tensor-core scoreboard.
- Holds NENT matrix-op entries from dispatch and tracks two source tags per entry until the common data bus (CDB) broadcasts them.
- Grants the single matrix unit round-robin among ready entries, times the fixed execution latency, then hands results to writeback.
- Speculative entries are squashed on flush; a resolve pulse makes all live entries non-speculative.

---
 rtl/fust_m_sched.sv | 188 ++++++++++++++++++
 tb/tb_fust_m_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fust_m_sched.sv
// rtl/fust_m_sched.sv - matrix-unit issue scheduler for the tensor-core FU status table
// Per-entry FREE/WAIT/READY/EXEC/DONE tracking, round-robin issue, oldest-first writeback.
module fust_m_sched #(
  parameter int NENT  = 4,
  parameter int TAG_W = 3,
  parameter int RD_W  = 5,
  parameter int LAT   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [RD_W-1:0]         disp_rd,
  input  logic [TAG_W-1:0]        disp_t1,
  input  logic [TAG_W-1:0]        disp_t2,
  input  logic                    disp_spec,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic                    resolve,
  input  logic                    flush,
  input  logic                    mu_ready,
  output logic                    mu_start,
  output logic [$clog2(NENT)-1:0] mu_entry,
  output logic                    wb_valid,
  output logic [RD_W-1:0]         wb_rd,
  input  logic                    wb_ready,
  output logic [NENT-1:0]         busy
);
  localparam int IW = $clog2(NENT);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {S_FREE, S_WAIT, S_READY, S_EXEC, S_DONE} st_t;

  st_t              st_q [NENT];
  st_t              st_d [NENT];
  logic [RD_W-1:0]  rd_q [NENT];
  logic [RD_W-1:0]  rd_d [NENT];
  logic [TAG_W-1:0] t1_q [NENT];
  logic [TAG_W-1:0] t1_d [NENT];
  logic [TAG_W-1:0] t2_q [NENT];
  logic [TAG_W-1:0] t2_d [NENT];
  logic [IW-1:0]    age_q [NENT];
  logic [IW-1:0]    age_d [NENT];
  logic [NENT-1:0]  spec_q, spec_d, leave;
  logic [IW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cdb_hit, alloc_any, g_found, wb_found, exec_busy, exec_spec, fin, disp_fire;
  logic [IW-1:0]    alloc_idx, grant, wb_idx, idx, stay_cnt, dec;
  logic [TAG_W-1:0] nt1, nt2;

  always_comb begin
    cdb_hit   = cdb_valid && (cdb_tag != '0);
    alloc_any = 1'b0;
    alloc_idx = '0;
    g_found   = 1'b0;
    grant     = '0;
    idx       = '0;
    wb_found  = 1'b0;
    wb_idx    = '0;
    exec_busy = 1'b0;
    exec_spec = 1'b0;
    busy      = '0;
    leave     = '0;
    stay_cnt  = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        alloc_any = 1'b1;
        alloc_idx = IW'(i);
      end
    end
    for (int k = 0; k < NENT; k++) begin
      idx = rr_q + IW'(k);
      if (!g_found && st_q[idx] == S_READY) begin
        g_found = 1'b1;
        grant   = idx;
      end
    end
    // DONE entries carry their rank in completion order; rank 0 is the oldest
    for (int i = 0; i < NENT; i++) begin
      busy[i] = (st_q[i] != S_FREE);
      if (st_q[i] == S_EXEC) begin
        exec_busy = 1'b1;
        exec_spec = spec_q[i];
      end
      if (st_q[i] == S_DONE && (!wb_found || age_q[i] < age_q[wb_idx])) begin
        wb_found = 1'b1;
        wb_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NENT; i++) begin
      leave[i] = (st_q[i] == S_DONE) &&
                 ((wb_ready && wb_found && wb_idx == IW'(i)) || (flush && spec_q[i]));
      if (st_q[i] == S_DONE && !leave[i]) stay_cnt = stay_cnt + 1'b1;
    end
    disp_ready = alloc_any;
    mu_start   = !exec_busy && mu_ready && g_found && !(flush && spec_q[grant]);
    mu_entry   = mu_start ? grant : '0;
    wb_valid   = wb_found;
    wb_rd      = wb_found ? rd_q[wb_idx] : '0;
    disp_fire  = disp_valid && alloc_any && !(flush && disp_spec);
    fin        = exec_busy && (cnt_q == '0) && !(flush && exec_spec);
    nt1        = (cdb_hit && disp_t1 == cdb_tag) ? '0 : disp_t1;
    nt2        = (cdb_hit && disp_t2 == cdb_tag) ? '0 : disp_t2;
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < NENT; i++) begin
      st_d[i]   = st_q[i];
      rd_d[i]   = rd_q[i];
      t1_d[i]   = t1_q[i];
      t2_d[i]   = t2_q[i];
      age_d[i]  = age_q[i];
      spec_d[i] = spec_q[i];
      case (st_q[i])
        S_FREE: begin
          if (disp_fire && alloc_idx == IW'(i)) begin
            st_d[i]   = (nt1 == '0 && nt2 == '0) ? S_READY : S_WAIT;
            rd_d[i]   = disp_rd;
            t1_d[i]   = nt1;
            t2_d[i]   = nt2;
            spec_d[i] = disp_spec;
          end
        end
        S_WAIT: begin
          if (t1_q[i] == '0 && t2_q[i] == '0) st_d[i] = S_READY;
          else if (cdb_hit) begin
            if (t1_q[i] == cdb_tag) t1_d[i] = '0;
            if (t2_q[i] == cdb_tag) t2_d[i] = '0;
          end
        end
        S_READY: if (mu_start && grant == IW'(i)) st_d[i] = S_EXEC;
        S_EXEC: begin
          if (cnt_q == '0) begin
            st_d[i]  = S_DONE;
            age_d[i] = stay_cnt;
          end
        end
        S_DONE: begin
          if (leave[i]) st_d[i] = S_FREE;
          else begin
            dec = '0;
            for (int j = 0; j < NENT; j++)
              if (leave[j] && age_q[j] < age_q[i]) dec = dec + 1'b1;
            age_d[i] = age_q[i] - dec;
          end
        end
        default: st_d[i] = S_FREE;
      endcase
      if (resolve) spec_d[i] = 1'b0;
      if (flush && spec_q[i] && st_q[i] != S_FREE) begin
        st_d[i]   = S_FREE;
        spec_d[i] = 1'b0;
      end
    end
    rr_d = mu_start ? grant + 1'b1 : rr_q;
    if (mu_start) cnt_d = CW'(LAT - 1);
    else if (exec_busy && !(flush && exec_spec) && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    else cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NENT; i++) begin
        st_q[i]  <= S_FREE;
        rd_q[i]  <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        age_q[i] <= '0;
      end
      spec_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        st_q[i]  <= st_d[i];
        rd_q[i]  <= rd_d[i];
        t1_q[i]  <= t1_d[i];
        t2_q[i]  <= t2_d[i];
        age_q[i] <= age_d[i];
      end
      spec_q <= spec_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fust_m_sched.sv
// tb/tb_fust_m_sched.sv - directed scenarios plus randomized model comparison for fust_m_sched
module tb_fust_m_sched;
  localparam int NENT = 4, TAG_W = 3, RD_W = 5, LAT = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic disp_valid, disp_spec, cdb_valid, resolve, flush, mu_ready, wb_ready;
  logic disp_ready, mu_start, wb_valid;
  logic [RD_W-1:0]  disp_rd, wb_rd;
  logic [TAG_W-1:0] disp_t1, disp_t2, cdb_tag;
  logic [1:0]       mu_entry;
  logic [NENT-1:0]  busy;
  int checks = 0;
  int failures = 0;

  fust_m_sched #(.NENT(NENT), .TAG_W(TAG_W), .RD_W(RD_W), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd(disp_rd), .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_spec(disp_spec),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .resolve(resolve), .flush(flush),
    .mu_ready(mu_ready), .mu_start(mu_start), .mu_entry(mu_entry), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_ready(wb_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic clear_in();
    disp_valid = 0; disp_rd = '0; disp_t1 = '0; disp_t2 = '0; disp_spec = 0;
    cdb_valid = 0; cdb_tag = '0; resolve = 0; flush = 0; mu_ready = 0; wb_ready = 0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    RST = 1;
    cyc();
    cyc();
    RST = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++; if (busy !== 4'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    checks++; if (mu_start !== 1'b0) begin failures++; $display("FAIL reset_mu_start got=%b exp=0", mu_start); end
    checks++; if (mu_entry !== 2'd0) begin failures++; $display("FAIL reset_mu_entry got=%0d exp=0", mu_entry); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    cyc();
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    mu_ready = 1; disp_valid = 1; disp_rd = 7;
    cyc();
    disp_valid = 0;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b1 || mu_entry !== 2'd0) begin failures++; $display("FAIL basic_start got=%b/%0d exp=1/0", mu_start, mu_entry); end
    n = 0;
    cyc();
    while (n < 20) begin
      @(negedge CLK);
      if (wb_valid) break;
      n++;
      cyc();
    end
    checks++; if (n != LAT) begin failures++; $display("FAIL basic_exec_cycles got=%0d exp=%0d", n, LAT); end
    checks++; if (wb_rd !== 5'd7) begin failures++; $display("FAIL basic_wb_rd got=%0d exp=7", wb_rd); end
    wb_ready = 1;
    cyc();
    wb_ready = 0;
    @(negedge CLK);
    checks++; if (busy !== 4'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL basic_free got=%b/%b exp=0000/0", busy, wb_valid); end
    cyc();
  endtask

  task automatic test_cdb();
    do_reset();
    mu_ready = 1; disp_valid = 1; disp_rd = 3; disp_t1 = 2; disp_t2 = 5;
    cyc();
    disp_valid = 0; disp_t1 = 0; disp_t2 = 0;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b0 || busy !== 4'b0001) begin failures++; $display("FAIL cdb_wait got=%b/%b exp=0/0001", mu_start, busy); end
    cyc();
    cdb_valid = 1; cdb_tag = 2;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b0) begin failures++; $display("FAIL cdb_tag2 got=%b exp=0", mu_start); end
    cyc();
    cdb_tag = 5;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b0) begin failures++; $display("FAIL cdb_tag5 got=%b exp=0", mu_start); end
    cyc();
    cdb_valid = 0; cdb_tag = 0;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b0) begin failures++; $display("FAIL cdb_plus1 got=%b exp=0", mu_start); end
    cyc();
    @(negedge CLK);
    checks++; if (mu_start !== 1'b1 || mu_entry !== 2'd0) begin failures++; $display("FAIL cdb_plus2 got=%b/%0d exp=1/0", mu_start, mu_entry); end
    cyc();
  endtask

  task automatic test_fill();
    int starts[$];
    int st_cyc[$];
    int wbs[$];
    int first_wb, acc5;
    logic full_ready;
    do_reset();
    mu_ready = 1; wb_ready = 1;
    first_wb = -1; acc5 = -1; full_ready = 1'bx;
    for (int c = 0; c < 40; c++) begin
      disp_valid = (c < 4) || (acc5 < 0);
      disp_rd = (c < 4) ? RD_W'(10 + c) : 5'd20;
      @(negedge CLK);
      if (mu_start) begin starts.push_back(int'(mu_entry)); st_cyc.push_back(c); end
      if (wb_valid && wb_ready) begin wbs.push_back(int'(wb_rd)); if (first_wb < 0) first_wb = c; end
      if (c == 4) full_ready = disp_ready;
      if (c >= 4 && disp_valid && disp_ready && acc5 < 0) acc5 = c;
      cyc();
    end
    disp_valid = 0;
    checks++; if (full_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", full_ready); end
    checks++; if (starts.size() != 5) begin failures++; $display("FAIL fill_start_count got=%0d exp=5", starts.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (starts.size() <= k || starts[k] != (k % NENT)) begin
        failures++; $display("FAIL fill_grant_order idx=%0d got=%0d exp=%0d", k, (starts.size() > k) ? starts[k] : -1, k % NENT);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (st_cyc.size() <= k + 1 || st_cyc[k+1] - st_cyc[k] != LAT + 1) begin
        failures++; $display("FAIL fill_start_spacing idx=%0d got=%0d exp=%0d", k, (st_cyc.size() > k + 1) ? st_cyc[k+1] - st_cyc[k] : -1, LAT + 1);
      end
    end
    checks++; if (acc5 != first_wb + 1) begin failures++; $display("FAIL fill_fifth_accept got=%0d exp=%0d", acc5, first_wb + 1); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wbs.size() <= k || wbs[k] != 10 + k) begin
        failures++; $display("FAIL fill_wb_order idx=%0d got=%0d exp=%0d", k, (wbs.size() > k) ? wbs[k] : -1, 10 + k);
      end
    end
  endtask

  task automatic test_flush();
    int nwb;
    do_reset();
    mu_ready = 1; disp_valid = 1; disp_rd = 1; disp_spec = 1;
    cyc();
    disp_rd = 2; disp_spec = 0;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b1 || mu_entry !== 2'd0) begin failures++; $display("FAIL flush_first_start got=%b/%0d exp=1/0", mu_start, mu_entry); end
    cyc();
    disp_valid = 0; flush = 1;
    @(negedge CLK);
    checks++; if (mu_start !== 1'b0 || busy !== 4'b0011) begin failures++; $display("FAIL flush_cycle got=%b/%b exp=0/0011", mu_start, busy); end
    cyc();
    flush = 0;
    @(negedge CLK);
    checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL flush_busy got=%b exp=0010", busy); end
    checks++; if (mu_start !== 1'b1 || mu_entry !== 2'd1) begin failures++; $display("FAIL flush_restart got=%b/%0d exp=1/1", mu_start, mu_entry); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_no_wb got=%b exp=0", wb_valid); end
    cyc();
    wb_ready = 1; nwb = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge CLK);
      if (wb_valid) begin
        nwb++;
        checks++; if (wb_rd !== 5'd2) begin failures++; $display("FAIL flush_wb_rd got=%0d exp=2", wb_rd); end
      end
      cyc();
    end
    checks++; if (nwb != 1) begin failures++; $display("FAIL flush_wb_count got=%0d exp=1", nwb); end
    checks++; if (busy !== 4'b0) begin failures++; $display("FAIL flush_drain_busy got=%b exp=0000", busy); end
  endtask

  task automatic test_flush_resolve();
    do_reset();
    disp_valid = 1; disp_rd = 4; disp_spec = 1;
    cyc();
    disp_rd = 5; disp_spec = 0; disp_t1 = 3;
    cyc();
    disp_rd = 6; disp_spec = 1; disp_t1 = 0;
    cyc();
    disp_rd = 9; disp_spec = 1; flush = 1; resolve = 1;
    cyc();
    disp_valid = 0; flush = 0; resolve = 0;
    @(negedge CLK);
    checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL flush_wins_busy got=%b exp=0010", busy); end
    cyc();
    disp_valid = 1; disp_spec = 1; disp_rd = 8; resolve = 1;
    cyc();
    disp_rd = 11; resolve = 0;
    cyc();
    disp_valid = 0; resolve = 1;
    cyc();
    resolve = 0; flush = 1;
    cyc();
    flush = 0;
    @(negedge CLK);
    checks++; if (busy !== 4'b0111) begin failures++; $display("FAIL resolve_survive got=%b exp=0111", busy); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int n, nwb;
    do_reset();
    mu_ready = 1; disp_valid = 1; disp_rd = 21;
    cyc();
    disp_rd = 22;
    cyc();
    disp_valid = 0;
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      if (wb_valid) break;
      n++;
      cyc();
    end
    cyc();
    @(negedge CLK);
    checks++; if (busy !== 4'b0011 || wb_valid !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%b/%b exp=0011/1", busy, wb_valid); end
    RST = 1;
    cyc();
    RST = 0;
    @(negedge CLK);
    checks++; if (busy !== 4'b0 || wb_valid !== 1'b0 || mu_start !== 1'b0 || disp_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_clear got=%b/%b/%b/%b exp=0000/0/0/1", busy, wb_valid, mu_start, disp_ready);
    end
    wb_ready = 1; nwb = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      @(negedge CLK);
      if (wb_valid) nwb++;
    end
    checks++; if (nwb != 0) begin failures++; $display("FAIL rstmid_no_wb got=%0d exp=0", nwb); end
    cyc();
  endtask

  // Reference: entries as records, completions in an ordered queue, timing as cycle stamps.
  task automatic test_random();
    bit               mv [NENT];
    bit               msp [NENT];
    logic [RD_W-1:0]  mrd [NENT];
    logic [TAG_W-1:0] mt1 [NENT];
    logic [TAG_W-1:0] mt2 [NENT];
    int               melig [NENT];
    int               dq[$];
    int               nq[$];
    int               ex, ex_end, rr, g, slot, i;
    bit               e_ready, e_start, e_wbv, hit, in_dq;
    logic [RD_W-1:0]  e_wbrd;
    logic [NENT-1:0]  e_busy;
    logic [1:0]       e_entry;
    do_reset();
    for (int k = 0; k < NENT; k++) begin mv[k] = 0; msp[k] = 0; end
    ex = -1; ex_end = 0; rr = 0;
    for (int now = 0; now < 3000; now++) begin
      RST        = ($urandom_range(0, 299) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_rd    = RD_W'($urandom);
      disp_t1    = $urandom_range(0, 1) ? 3'd0 : TAG_W'($urandom_range(1, 7));
      disp_t2    = $urandom_range(0, 1) ? 3'd0 : TAG_W'($urandom_range(1, 7));
      disp_spec  = ($urandom_range(0, 9) < 3);
      cdb_valid  = ($urandom_range(0, 9) < 4);
      cdb_tag    = TAG_W'($urandom_range(0, 7));
      resolve    = ($urandom_range(0, 19) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      mu_ready   = ($urandom_range(0, 3) != 0);
      wb_ready   = ($urandom_range(0, 9) < 6);
      @(negedge CLK);
      slot = -1;
      for (int k = 0; k < NENT; k++) begin
        e_busy[k] = mv[k];
        if (!mv[k] && slot < 0) slot = k;
      end
      e_ready = (slot >= 0);
      g = -1;
      for (int k = 0; k < NENT; k++) begin
        i = (rr + k) % NENT;
        in_dq = 0;
        foreach (dq[j]) if (dq[j] == i) in_dq = 1;
        if (g < 0 && mv[i] && ex != i && !in_dq && mt1[i] == 0 && mt2[i] == 0 && melig[i] <= now) g = i;
      end
      e_start = (ex < 0) && mu_ready && (g >= 0) && !(flush && msp[(g < 0) ? 0 : g]);
      e_entry = e_start ? 2'(g) : 2'd0;
      e_wbv   = (dq.size() > 0);
      e_wbrd  = e_wbv ? mrd[dq[0]] : '0;
      checks++; if (disp_ready !== e_ready) begin failures++; $display("FAIL rnd_disp_ready cyc=%0d got=%b exp=%b", now, disp_ready, e_ready); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", now, busy, e_busy); end
      checks++; if (mu_start !== e_start) begin failures++; $display("FAIL rnd_mu_start cyc=%0d got=%b exp=%b", now, mu_start, e_start); end
      checks++; if (mu_entry !== e_entry) begin failures++; $display("FAIL rnd_mu_entry cyc=%0d got=%0d exp=%0d", now, mu_entry, e_entry); end
      checks++; if (wb_valid !== e_wbv) begin failures++; $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", now, wb_valid, e_wbv); end
      checks++; if (wb_rd !== e_wbrd) begin failures++; $display("FAIL rnd_wb_rd cyc=%0d got=%0d exp=%0d", now, wb_rd, e_wbrd); end
      if (RST) begin
        for (int k = 0; k < NENT; k++) begin mv[k] = 0; msp[k] = 0; end
        dq = {}; ex = -1; rr = 0;
      end else begin
        if (e_wbv && wb_ready) begin mv[dq[0]] = 0; dq.pop_front(); end
        if (ex >= 0 && now == ex_end) begin dq.push_back(ex); ex = -1; end
        if (e_start) begin ex = g; ex_end = now + LAT; rr = (g + 1) % NENT; end
        hit = cdb_valid && (cdb_tag != 0);
        for (int k = 0; k < NENT; k++) begin
          if (hit && mv[k] && (mt1[k] != 0 || mt2[k] != 0)) begin
            if (mt1[k] == cdb_tag) mt1[k] = 0;
            if (mt2[k] == cdb_tag) mt2[k] = 0;
            if (mt1[k] == 0 && mt2[k] == 0) melig[k] = now + 2;
          end
        end
        if (flush) begin
          for (int k = 0; k < NENT; k++) begin
            if (mv[k] && msp[k]) begin
              mv[k] = 0;
              if (ex == k) ex = -1;
            end
          end
          nq = {};
          foreach (dq[j]) if (mv[dq[j]]) nq.push_back(dq[j]);
          dq = nq;
        end
        if (disp_valid && e_ready && !(flush && disp_spec)) begin
          mv[slot]    = 1;
          mrd[slot]   = disp_rd;
          mt1[slot]   = (hit && disp_t1 == cdb_tag) ? '0 : disp_t1;
          mt2[slot]   = (hit && disp_t2 == cdb_tag) ? '0 : disp_t2;
          msp[slot]   = disp_spec;
          melig[slot] = now + 1;
        end
        if (resolve) for (int k = 0; k < NENT; k++) msp[k] = 0;
      end
      cyc();
    end
    RST = 0;
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_basic();
    test_cdb();
    test_fill();
    test_flush();
    test_flush_resolve();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
